// File: rtl/mux_seq_pkg.sv
// Shared types and scan-order constants for the mux select sequencer.
// Optional build macro: MUX_SEQ_MSB_FIRST_EN reverses the scan order (MSB first).
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SEL_W_DEF = 3;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  // First and last select index of a scan; word bit i always maps to sel == i.
  function automatic int first_idx(input int sel_w);
    return MSB_FIRST ? (1 << sel_w) - 1 : 0;
  endfunction

  function automatic int last_idx(input int sel_w);
    return MSB_FIRST ? 0 : (1 << sel_w) - 1;
  endfunction

endpackage

// File: rtl/mux_seq_hold_timer.sv
// Dwell timer: counts HOLD_CYCLES enabled clocks per select value and
// flags the clock edge on which the mux output is captured.
module mux_seq_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // Cycles remaining before capture; reload value matches an elapsed count of 0.
  logic [CNT_W-1:0] remain;

  assign expire = en && (remain == '0);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      remain <= RELOAD;
    end else if (en) begin
      remain <= expire ? RELOAD : remain - ONE;
    end
  end

  a_hold_cycles_legal: assert property (@(posedge clk) HOLD_CYCLES >= 1);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Steps an external N:1 mux select through every index, streams the sampled
// bits serially and reassembles them into a word. Macro: MUX_SEQ_MSB_FIRST_EN.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SEL_W       = SEL_W_DEF,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mux_out,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic [(1<<SEL_W)-1:0]   word_out,
  output logic                    word_valid
);

  localparam logic [SEL_W-1:0] FIRST = SEL_W'(first_idx(SEL_W));
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(last_idx(SEL_W));
  localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);

  state_e           state;
  state_e           state_nxt;
  logic             timer_load;
  logic             timer_en;
  logic             capture;
  logic [SEL_W-1:0] sel_step;

  assign sel_step = MSB_FIRST ? sel - ONE : sel + ONE;

  mux_seq_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (timer_en),
    .expire (capture)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STEP;
      STEP:    if (capture && (sel == LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    timer_load = (state == IDLE);
    timer_en   = (state == STEP);
  end

  // Registered datapath: select, serial bit, reassembled word and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= FIRST;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      // NOTE: word_out is a plain register, so it is reset to drop any partial word.
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      bit_valid  <= 1'b0;
      word_valid <= 1'b0;
      case (state)
        IDLE: sel <= FIRST;
        STEP: begin
          if (capture) begin
            word_out[sel] <= mux_out;
            bit_out       <= mux_out;
            bit_valid     <= 1'b1;
            if (sel == LAST) begin
              word_valid <= 1'b1;
            end else begin
              sel <= sel_step;
            end
          end
        end
        DONE:    sel <= FIRST;
        default: sel <= FIRST;
      endcase
    end
  end

endmodule
